div_ratio_decoder: RTL

- Measurement block for the fractional loop divider: decodes the per-cycle division-ratio stream (div_ctrl, integer N plus the SDM dither) back into the averaged fractional ratio.
- Accumulates 2^WIN_LOG2 accepted samples, then reports integer part, 16-bit fraction and min/max ratio.
- Used for built-in self-check of the SDM and for closed-loop calibration of N/sdm_in.
- Runs in the div_clk_out domain; each div_ctrl update arrives with a valid strobe.

---
 rtl/div_ratio_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/div_ratio_decoder.sv
// div_ratio_decoder
//   Decodes the per-cycle division-ratio stream of the fractional loop divider
//   back into the averaged fractional ratio. One window covers 2^WIN_LOG2
//   accepted samples. At the end of a window the block reports:
//     - the integer part of the average,
//     - the MSB-aligned fraction,
//     - the min and max sample seen in that window.
//
// Ports
//   clk        block clock (divided clock domain)
//   rst        synchronous reset, active-high
//   start      single-cycle pulse; opens (or restarts) a measurement window
//   ratio_vld  div_ctrl carries a sample this cycle
//   div_ctrl   unsigned ratio sample, 0..63
//   busy       high while a window is accumulating
//   done       single-cycle pulse; result outputs updated with it
//   n_est      integer part of the averaged ratio
//   frac_est   fractional part of the averaged ratio, MSB-aligned
//   min_ratio  smallest sample of the last window
//   max_ratio  largest sample of the last window
module div_ratio_decoder #(
  parameter int WIN_LOG2 = 10,
  parameter int FRAC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ratio_vld,
  input  logic [5:0]        div_ctrl,
  output logic              busy,
  output logic              done,
  output logic [5:0]        n_est,
  output logic [FRAC_W-1:0] frac_est,
  output logic [5:0]        min_ratio,
  output logic [5:0]        max_ratio
);

  // 63 * 2^WIN_LOG2 always fits in 6+WIN_LOG2 bits, so acc never wraps.
  localparam int ACC_W = 6 + WIN_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          state_q,   state_d;
  logic [ACC_W-1:0]    acc_q,     acc_d;
  logic [WIN_LOG2-1:0] cnt_q,     cnt_d;
  logic [5:0]          run_min_q, run_min_d;
  logic [5:0]          run_max_q, run_max_d;
  logic                done_q,    done_d;
  logic [5:0]          n_q,       n_d;
  logic [FRAC_W-1:0]   frac_q,    frac_d;
  logic [5:0]          min_q,     min_d;
  logic [5:0]          max_q,     max_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    done_d    = 1'b0;
    n_d       = n_q;
    frac_d    = frac_q;
    min_d     = min_q;
    max_d     = max_q;

    case (state_q)
      S_IDLE: begin
        // A sample arriving with start is dropped: counting begins next edge.
        if (start) begin
          state_d   = S_ACCUM;
          acc_d     = '0;
          cnt_d     = '0;
          run_min_d = 6'd63;
          run_max_d = 6'd0;
        end
      end
      S_ACCUM: begin
        if (start) begin
          // Restart: the partial window and any same-edge sample are dropped.
          acc_d     = '0;
          cnt_d     = '0;
          run_min_d = 6'd63;
          run_max_d = 6'd0;
        end else if (ratio_vld) begin
          acc_d     = acc_q + ACC_W'(div_ctrl);
          cnt_d     = cnt_q + WIN_LOG2'(1);
          run_min_d = (div_ctrl < run_min_q) ? div_ctrl : run_min_q;
          run_max_d = (div_ctrl > run_max_q) ? div_ctrl : run_max_q;
          // cnt is all-ones on the last sample of the window.
          if (&cnt_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        // The top 6 bits of acc are the integer part. They cannot exceed 63,
        // so saturating to 63 is automatic.
        n_d    = acc_q[ACC_W-1:WIN_LOG2];
        frac_d = FRAC_W'(acc_q[WIN_LOG2-1:0]) << (FRAC_W - WIN_LOG2);
        min_d  = run_min_q;
        max_d  = run_max_q;
        if (start) begin
          state_d   = S_ACCUM;
          acc_d     = '0;
          cnt_d     = '0;
          run_min_d = 6'd63;
          run_max_d = 6'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      run_min_q <= 6'd63;
      run_max_q <= 6'd0;
      done_q    <= 1'b0;
      n_q       <= '0;
      frac_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      done_q    <= done_d;
      n_q       <= n_d;
      frac_q    <= frac_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign busy      = (state_q == S_ACCUM);
  assign done      = done_q;
  assign n_est     = n_q;
  assign frac_est  = frac_q;
  assign min_ratio = min_q;
  assign max_ratio = max_q;

endmodule
